// File: rtl/mcse_ahb_payload_sub_pkg.sv
// Shared types and constants for the MCSE AHB-Lite payload subordinate.
package mcse_ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   // Data-phase state of the subordinate
   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_ERR1,
      S_ERR2
   } sub_state_e;

endpackage

// File: rtl/mcse_ahb_payload_sub_if.sv
// AHB-Lite bus bundle between the MCSE bus-requester port and the payload subordinate.
interface mcse_ahb_payload_sub_if #(
   parameter int pAHB_DATA_WIDTH  = 32,
   parameter int pAHB_ADDR_WIDTH  = 32,
   parameter int pAHB_HRESP_WIDTH = 2
);
   logic                        I_hsel;
   logic [pAHB_ADDR_WIDTH-1:0]  I_haddr;
   logic [1:0]                  I_htrans;
   logic                        I_hwrite;
   logic [2:0]                  I_hsize;
   logic [2:0]                  I_hburst;
   logic                        I_hready;
   logic [pAHB_DATA_WIDTH-1:0]  I_hwdata;
   logic [pAHB_DATA_WIDTH-1:0]  O_hrdata;
   logic                        O_hreadyout;
   logic [pAHB_HRESP_WIDTH-1:0] O_hresp;

   modport slave (
      input  I_hsel, I_haddr, I_htrans, I_hwrite, I_hsize, I_hburst, I_hready, I_hwdata,
      output O_hrdata, O_hreadyout, O_hresp
   );

   modport master (
      output I_hsel, I_haddr, I_htrans, I_hwrite, I_hsize, I_hburst, I_hready, I_hwdata,
      input  O_hrdata, O_hreadyout, O_hresp
   );
endinterface

// File: rtl/mcse_ahb_payload_sub_store.sv
// Payload slot storage: NUM_SLOTS x WORDS x DATA_W words, a pending mask that is
// set when the last word of a slot is written, lowest-index presentation and
// a valid/ack handshake toward local logic.
module mcse_payload_store #(
   parameter int DATA_W    = 32,
   parameter int WORDS     = 8,
   parameter int NUM_SLOTS = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
   input  logic [$clog2(WORDS)-1:0]     wr_word,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
   input  logic [$clog2(WORDS)-1:0]     rd_word,
   output logic [DATA_W-1:0]            rd_data,
   output logic [NUM_SLOTS-1:0]         pending,
   input  logic                         ack,
   output logic                         payload_valid,
   output logic [$clog2(NUM_SLOTS)-1:0] payload_slot,
   output logic [WORDS*DATA_W-1:0]      payload_data
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int WW = $clog2(WORDS);

   logic [DATA_W-1:0]    mem [NUM_SLOTS][WORDS];
   logic [NUM_SLOTS-1:0] pending_q;
   logic [NUM_SLOTS-1:0] pending_d;
   logic [SW-1:0]        sel_slot;

   // Slot word storage; cleared on reset so an aborted burst leaves nothing behind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int w = 0; w < WORDS; w++) begin
               mem[s][w] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[wr_slot][wr_word] <= wr_data;
      end
   end

   // Lowest pending index wins presentation
   always_comb begin
      sel_slot = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (pending_q[i]) sel_slot = SW'(i);
      end
   end

   // Ack retires the presented slot; completion of another slot in the same cycle also lands
   always_comb begin
      pending_d = pending_q;
      if (ack && (|pending_q)) pending_d[sel_slot] = 1'b0;
      if (wr_en && (wr_word == WW'(WORDS - 1))) pending_d[wr_slot] = 1'b1;
   end

   // Pending mask register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   // Flatten the presented slot, word 0 in the least significant bits
   always_comb begin
      payload_data = '0;
      for (int w = 0; w < WORDS; w++) begin
         payload_data[w*DATA_W +: DATA_W] = mem[sel_slot][w];
      end
   end

   assign rd_data       = mem[rd_slot][rd_word];
   assign pending       = pending_q;
   assign payload_valid = |pending_q;
   assign payload_slot  = sel_slot;

endmodule

// File: rtl/mcse_ahb_payload_sub.sv
// MCSE system-side mailbox: AHB-Lite subordinate that assembles word writes into
// payload slots and serves word reads of any slot.
// Optional build macro MCSE_AHB_SUB_RDWAIT_EN: each read data phase takes one wait
// state so the slot storage can be mapped onto a synchronous RAM.
module mcse_ahb_payload_sub
   import mcse_ahb_pkg::*;
#(
   parameter int                   pAHB_DATA_WIDTH    = 32,
   parameter int                   pAHB_ADDR_WIDTH    = 32,
   parameter int                   pAHB_HRESP_WIDTH   = 2,
   parameter int                   pPAYLOAD_SIZE_BITS = 256,
   parameter int                   NUM_SLOTS          = 4,
   parameter logic [pAHB_ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   mcse_ahb_payload_sub_if.slave          bus,
   output logic                           O_payload_valid,
   output logic [$clog2(NUM_SLOTS)-1:0]   O_payload_slot,
   output logic [pPAYLOAD_SIZE_BITS-1:0]  O_payload_data,
   input  logic                           I_payload_ack
);
   localparam int WORDS    = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
   localparam int WW       = $clog2(WORDS);
   localparam int SW       = $clog2(NUM_SLOTS);
   localparam int SLOT_LSB = $clog2(pPAYLOAD_SIZE_BITS / 8);
   localparam logic [pAHB_ADDR_WIDTH-1:0] WIN_BYTES =
      pAHB_ADDR_WIDTH'(NUM_SLOTS * (pPAYLOAD_SIZE_BITS / 8));

   sub_state_e                 state_q, state_d;
   logic                       dp_write_p1;
   logic [SW-1:0]              dp_slot_p1;
   logic [WW-1:0]              dp_word_p1;
   logic [pAHB_DATA_WIDTH-1:0] hrdata_p1;

   logic [pAHB_ADDR_WIDTH-1:0] offset;
   logic [SW-1:0]              a_slot;
   logic [WW-1:0]              a_word;
   logic                       addr_acc, addr_take, a_err, a_read_ok;
   logic                       in_win, completing_same;
   logic                       wr_commit, fwd_hit, rd_stall, hreadyout;
   logic [pAHB_DATA_WIDTH-1:0] rd_data;
   logic [NUM_SLOTS-1:0]       pending;
   logic                       unused_burst;

   // Address-phase decode
   assign offset    = bus.I_haddr - BASE_ADDR;
   assign a_slot    = offset[SLOT_LSB +: SW];
   assign a_word    = offset[2 +: WW];
   assign in_win    = offset < WIN_BYTES;
   assign addr_acc  = bus.I_hsel && bus.I_hready &&
                      ((bus.I_htrans == NONSEQ) || (bus.I_htrans == SEQ));
   assign addr_take = addr_acc && hreadyout;

   // A write data phase that finishes a slot this cycle makes that slot pending already
   assign wr_commit       = (state_q == S_DATA) && dp_write_p1;
   assign completing_same = wr_commit && (dp_word_p1 == WW'(WORDS - 1)) && (dp_slot_p1 == a_slot);
   assign a_err           = !in_win || (bus.I_haddr[1:0] != 2'b00) || (bus.I_hsize != HSIZE_WORD) ||
                            (bus.I_hwrite && (pending[a_slot] || completing_same));
   assign a_read_ok       = addr_take && !a_err && !bus.I_hwrite;
   assign fwd_hit         = wr_commit && (dp_slot_p1 == a_slot) && (dp_word_p1 == a_word);

`ifdef MCSE_AHB_SUB_RDWAIT_EN
   logic rd_wait_p1;

   // First cycle of every read data phase is a wait state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_wait_p1 <= 1'b0;
      else        rd_wait_p1 <= a_read_ok;
   end

   assign rd_stall = (state_q == S_DATA) && !dp_write_p1 && rd_wait_p1;
`else
   assign rd_stall = 1'b0;
`endif

   assign hreadyout = (state_q != S_ERR1) && !rd_stall;

   // Data-phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next data-phase state: errors run ERR1 then ERR2, stalls hold DATA
   always_comb begin
      state_d = S_IDLE;
      if (state_q == S_ERR1)  state_d = S_ERR2;
      else if (rd_stall)      state_d = S_DATA;
      else if (addr_take)     state_d = a_err ? S_ERR1 : S_DATA;
   end

   // Capture the accepted beat for its data phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_write_p1 <= 1'b0;
         dp_slot_p1  <= '0;
         dp_word_p1  <= '0;
      end else if (addr_take) begin
         dp_write_p1 <= bus.I_hwrite;
         dp_slot_p1  <= a_slot;
         dp_word_p1  <= a_word;
      end
   end

   // Read data registered at the address phase; a concurrent write to the same word is forwarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         hrdata_p1 <= '0;
      else if (a_read_ok) hrdata_p1 <= fwd_hit ? bus.I_hwdata : rd_data;
   end

   mcse_payload_store #(
      .DATA_W    (pAHB_DATA_WIDTH),
      .WORDS     (WORDS),
      .NUM_SLOTS (NUM_SLOTS)
   ) u_store (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_commit),
      .wr_slot       (dp_slot_p1),
      .wr_word       (dp_word_p1),
      .wr_data       (bus.I_hwdata),
      .rd_slot       (a_slot),
      .rd_word       (a_word),
      .rd_data       (rd_data),
      .pending       (pending),
      .ack           (I_payload_ack),
      .payload_valid (O_payload_valid),
      .payload_slot  (O_payload_slot),
      .payload_data  (O_payload_data)
   );

   assign bus.O_hrdata    = hrdata_p1;
   assign bus.O_hreadyout = hreadyout;
   assign bus.O_hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ?
                            pAHB_HRESP_WIDTH'(HRESP_ERROR) : pAHB_HRESP_WIDTH'(HRESP_OKAY);

   // Bursts are decoded beat by beat, so the burst type carries no information here
   assign unused_burst = ^bus.I_hburst;

endmodule

// File: tb/tb_mcse_ahb_payload_sub.sv
// Directed bench for the MCSE AHB payload subordinate.
module tb_mcse_ahb_payload_sub;
   import mcse_ahb_pkg::*;

   localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef MCSE_AHB_SUB_RDWAIT_EN
   localparam int RD_WAITS = 1;
`else
   localparam int RD_WAITS = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid;
   logic [1:0]   pslot;
   logic [255:0] pdata;
   logic         ack;

   always #5 clk = ~clk;

   mcse_ahb_payload_sub_if bus ();
   assign bus.I_hready = bus.O_hreadyout;

   mcse_ahb_payload_sub dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .O_payload_valid (valid),
      .O_payload_slot  (pslot),
      .O_payload_data  (pdata),
      .I_payload_ack   (ack)
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] q_addr  [16];
   logic [31:0] q_wdata [16];
   logic        q_wr    [16];
   logic [2:0]  q_size  [16];
   logic [1:0]  r_resp  [16];
   logic [31:0] r_rdata [16];
   int          wait_cnt;

   task automatic bus_idle();
      bus.I_hsel   = 1'b0;
      bus.I_haddr  = '0;
      bus.I_htrans = IDLE;
      bus.I_hwrite = 1'b0;
      bus.I_hsize  = HSIZE_WORD;
      bus.I_hburst = 3'b000;
      bus.I_hwdata = '0;
   endtask

   task automatic set_beat(input int i, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [2:0] size);
      q_addr[i]  = addr;
      q_wr[i]    = wr;
      q_wdata[i] = wdata;
      q_size[i]  = size;
   endtask

   // Pipelined AHB master: called and returns at 1 time unit after a rising edge
   task automatic run_seq(input int n);
      int a, d, cyc;
      a = 0; d = -1; cyc = 0; wait_cnt = 0;
      while ((a < n || d >= 0) && cyc < 200) begin
         if (a < n) begin
            bus.I_hsel   = 1'b1;
            bus.I_haddr  = q_addr[a];
            bus.I_htrans = NONSEQ;
            bus.I_hwrite = q_wr[a];
            bus.I_hsize  = q_size[a];
         end else begin
            bus.I_hsel   = 1'b0;
            bus.I_htrans = IDLE;
            bus.I_hwrite = 1'b0;
         end
         if (d >= 0 && q_wr[d]) bus.I_hwdata = q_wdata[d];
         @(negedge clk);
         if (bus.O_hreadyout) begin
            if (d >= 0) begin
               r_resp[d]  = bus.O_hresp;
               r_rdata[d] = bus.O_hrdata;
            end
            d = (a < n) ? a : -1;
            if (a < n) a++;
         end else if (d >= 0) begin
            wait_cnt++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      tests++;
      if (cyc >= 200) begin
         fails++;
         $display("FAIL seq_timeout: beats left a=%0d d=%0d, required completion in 200 cycles", a, d);
      end
      bus_idle();
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ack   = 1'b0;
      bus_idle();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.O_hreadyout !== 1'b1) begin fails++; $display("FAIL rst_hreadyout got %b exp 1", bus.O_hreadyout); end
      tests++; if (bus.O_hresp !== HRESP_OKAY) begin fails++; $display("FAIL rst_hresp got %b exp 00", bus.O_hresp); end
      tests++; if (bus.O_hrdata !== 32'h0) begin fails++; $display("FAIL rst_hrdata got %h exp 0", bus.O_hrdata); end
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", valid); end
      tests++; if (pslot !== 2'd0) begin fails++; $display("FAIL rst_slot got %0d exp 0", pslot); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) set_beat(i, BASE + 32'h20 + 32'(4*i), 1'b1, 32'h1111_0000 + 32'(i), HSIZE_WORD);
      run_seq(8);
      for (int i = 0; i < 8; i++) begin
         tests++; if (r_resp[i] !== HRESP_OKAY) begin fails++; $display("FAIL b2b_resp[%0d] got %b exp 00", i, r_resp[i]); end
      end
      tests++; if (wait_cnt !== 0) begin fails++; $display("FAIL b2b_waits got %0d exp 0", wait_cnt); end
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b exp 1", valid); end
      tests++; if (pslot !== 2'd1) begin fails++; $display("FAIL b2b_slot got %0d exp 1", pslot); end
      tests++; if (pdata[31:0] !== 32'h1111_0000) begin fails++; $display("FAIL b2b_word0 got %h exp 11110000", pdata[31:0]); end
      tests++; if (pdata[255:224] !== 32'h1111_0007) begin fails++; $display("FAIL b2b_word7 got %h exp 11110007", pdata[255:224]); end
   endtask

   task automatic test_pending_error();
      set_beat(0, BASE + 32'h2C, 1'b1, 32'hBAD0_0003, HSIZE_WORD);
      run_seq(1);
      tests++; if (r_resp[0] !== HRESP_ERROR) begin fails++; $display("FAIL pend_err_resp got %b exp 01", r_resp[0]); end
      tests++; if (wait_cnt !== 1) begin fails++; $display("FAIL pend_err_waits got %0d exp 1", wait_cnt); end
      tests++; if (pdata[127:96] !== 32'h1111_0003) begin fails++; $display("FAIL pend_err_data got %h exp 11110003", pdata[127:96]); end
      do_ack();
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL pend_ack_valid got %b exp 0", valid); end
      set_beat(0, BASE + 32'h2C, 1'b1, 32'h3333_3333, HSIZE_WORD);
      set_beat(1, BASE + 32'h2C, 1'b0, 32'h0, HSIZE_WORD);
      run_seq(2);
      tests++; if (r_resp[0] !== HRESP_OKAY) begin fails++; $display("FAIL rewrite_resp got %b exp 00", r_resp[0]); end
      tests++; if (r_rdata[1] !== 32'h3333_3333) begin fails++; $display("FAIL rewrite_read got %h exp 33333333", r_rdata[1]); end
   endtask

   task automatic test_priority();
      for (int i = 0; i < 8; i++) begin
         set_beat(i,     BASE + 32'h40 + 32'(4*i), 1'b1, 32'h2222_0000 + 32'(i), HSIZE_WORD);
         set_beat(i + 8, BASE + 32'(4*i),          1'b1, 32'h0000_AA00 + 32'(i), HSIZE_WORD);
      end
      run_seq(16);
      tests++; if (wait_cnt !== 0) begin fails++; $display("FAIL prio_waits got %0d exp 0", wait_cnt); end
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL prio_valid got %b exp 1", valid); end
      tests++; if (pslot !== 2'd0) begin fails++; $display("FAIL prio_first_slot got %0d exp 0", pslot); end
      tests++; if (pdata[31:0] !== 32'h0000_AA00) begin fails++; $display("FAIL prio_first_data got %h exp 0000aa00", pdata[31:0]); end
      do_ack();
      tests++; if (pslot !== 2'd2) begin fails++; $display("FAIL prio_second_slot got %0d exp 2", pslot); end
      tests++; if (pdata[255:224] !== 32'h2222_0007) begin fails++; $display("FAIL prio_second_data got %h exp 22220007", pdata[255:224]); end
      do_ack();
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL prio_drain_valid got %b exp 0", valid); end
   endtask

   task automatic test_illegal();
      set_beat(0, BASE + 32'h80, 1'b1, 32'h5555_5555, HSIZE_WORD);
      set_beat(1, BASE + 32'h40, 1'b1, 32'h5555_5555, 3'b001);
      set_beat(2, BASE + 32'h02, 1'b0, 32'h0, HSIZE_WORD);
      run_seq(3);
      for (int i = 0; i < 3; i++) begin
         tests++; if (r_resp[i] !== HRESP_ERROR) begin fails++; $display("FAIL illegal_resp[%0d] got %b exp 01", i, r_resp[i]); end
      end
      tests++; if (wait_cnt !== 3) begin fails++; $display("FAIL illegal_waits got %0d exp 3", wait_cnt); end
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL illegal_valid got %b exp 0", valid); end
      set_beat(0, BASE + 32'h40, 1'b0, 32'h0, HSIZE_WORD);
      set_beat(1, BASE + 32'h00, 1'b0, 32'h0, HSIZE_WORD);
      run_seq(2);
      tests++; if (r_rdata[0] !== 32'h2222_0000) begin fails++; $display("FAIL illegal_slot2_kept got %h exp 22220000", r_rdata[0]); end
      tests++; if (r_rdata[1] !== 32'h0000_AA00) begin fails++; $display("FAIL illegal_slot0_kept got %h exp 0000aa00", r_rdata[1]); end
   endtask

   task automatic test_forwarding();
      set_beat(0, BASE + 32'h74, 1'b1, 32'hDEAD_BEEF, HSIZE_WORD);
      set_beat(1, BASE + 32'h74, 1'b0, 32'h0, HSIZE_WORD);
      run_seq(2);
      tests++; if (r_resp[1] !== HRESP_OKAY) begin fails++; $display("FAIL fwd_resp got %b exp 00", r_resp[1]); end
      tests++; if (r_rdata[1] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL fwd_rdata got %h exp deadbeef", r_rdata[1]); end
      tests++; if (wait_cnt !== RD_WAITS) begin fails++; $display("FAIL fwd_waits got %0d exp %0d", wait_cnt, RD_WAITS); end
   endtask

   task automatic test_reset_midburst();
      for (int i = 0; i <= 4; i++) begin
         bus.I_hsel   = 1'b1;
         bus.I_haddr  = BASE + 32'h60 + 32'(4*i);
         bus.I_htrans = NONSEQ;
         bus.I_hwrite = 1'b1;
         bus.I_hsize  = HSIZE_WORD;
         if (i > 0) bus.I_hwdata = 32'h3333_0000 + 32'(i - 1);
         @(posedge clk); #1;
      end
      bus.I_hwdata = 32'h3333_0004;
      #2 rst_n = 1'b0;
      #1;
      tests++; if (bus.O_hreadyout !== 1'b1) begin fails++; $display("FAIL mid_rst_hreadyout got %b exp 1", bus.O_hreadyout); end
      tests++; if (bus.O_hresp !== HRESP_OKAY) begin fails++; $display("FAIL mid_rst_hresp got %b exp 00", bus.O_hresp); end
      tests++; if (bus.O_hrdata !== 32'h0) begin fails++; $display("FAIL mid_rst_hrdata got %h exp 0", bus.O_hrdata); end
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b exp 0", valid); end
      tests++; if (pdata !== 256'h0) begin fails++; $display("FAIL mid_rst_pdata got %h exp 0", pdata); end
      bus_idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_beat(0, BASE + 32'h60, 1'b0, 32'h0, HSIZE_WORD);
      set_beat(1, BASE + 32'h20, 1'b0, 32'h0, HSIZE_WORD);
      run_seq(2);
      tests++; if (r_rdata[0] !== 32'h0) begin fails++; $display("FAIL mid_rst_slot3_cleared got %h exp 0", r_rdata[0]); end
      tests++; if (r_rdata[1] !== 32'h0) begin fails++; $display("FAIL mid_rst_slot1_cleared got %h exp 0", r_rdata[1]); end
      tests++; if (valid !== 1'b0) begin fails++; $display("FAIL mid_rst_no_pending got %b exp 0", valid); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_pending_error();
      test_priority();
      test_illegal();
      test_forwarding();
      test_reset_midburst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
